// File: rtl/fifo_drain.sv
`default_nettype none
// ============================================================================
// Module  : fifo_drain
// Purpose : Read-side master for the pixel fifo; re-presents pixels on a
//           valid/ready stream through a 2-entry skid buffer.
// Revision: 1.0
// ============================================================================
module fifo_drain #(
  parameter int MEM_LENGTH = 8,
  parameter int PIX_WIDTH  = 16,
  parameter int TIMEOUT    = 15,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  enable_i,
  input  logic [MEM_LENGTH-1:0] fill_i,
  output logic                  req_out_o,
  input  logic                  ack_in_i,
  input  logic [PIX_WIDTH-1:0]  pix_in_i,
  output logic                  pix_valid_o,
  input  logic                  pix_ready_i,
  output logic [PIX_WIDTH-1:0]  pix_data_o,
  output logic [CNT_WIDTH-1:0]  drained_o,
  output logic                  timeout_err_o,
  input  logic                  clear_err_i
);

  localparam int                WAIT_W    = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2,
    ERR  = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [WAIT_W-1:0]      wait_q, wait_d;
  logic                   timeout_err_q, timeout_err_d;
  logic                   req_q, req_d;
  logic [CNT_WIDTH-1:0]   drained_q, drained_d;

  logic [PIX_WIDTH-1:0]   mem0_q, mem0_d;
  logic [PIX_WIDTH-1:0]   mem1_q, mem1_d;
  logic                   head_q, head_d;
  logic [1:0]             count_q, count_d;

  logic                   push;
  logic                   pop;
  logic                   wr_idx;

  // ---------------------------------------------------------------------------
  // Request FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    wait_d        = '0;
    timeout_err_d = timeout_err_q;
    push          = 1'b0;

    if (clear_err_i) begin
      timeout_err_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (enable_i && (fill_i != '0) && (count_q != 2'd2)) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (ack_in_i) begin
          push    = 1'b1;
          state_d = GAP;
        end else if (wait_q == WAIT_LAST) begin
          state_d       = ERR;
          timeout_err_d = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      ERR: begin
        if (clear_err_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Registered so req_out is a clean flop output to the fifo.
    req_d = (state_d == REQ);
  end

  // ---------------------------------------------------------------------------
  // Skid buffer and drained counter
  // ---------------------------------------------------------------------------
  assign pop    = (count_q != 2'd0) && pix_ready_i;
  // Tail slot sits one past the head when an entry is already held.
  assign wr_idx = head_q ^ count_q[0];

  always_comb begin
    mem0_d    = mem0_q;
    mem1_d    = mem1_q;
    head_d    = head_q;
    count_d   = count_q;
    drained_d = drained_q;

    if (push) begin
      if (wr_idx) begin
        mem1_d = pix_in_i;
      end else begin
        mem0_d = pix_in_i;
      end
      drained_d = drained_q + CNT_WIDTH'(1);
    end

    if (pop) begin
      head_d = ~head_q;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      wait_q        <= '0;
      timeout_err_q <= 1'b0;
      req_q         <= 1'b0;
      drained_q     <= '0;
      mem0_q        <= '0;
      mem1_q        <= '0;
      head_q        <= 1'b0;
      count_q       <= 2'd0;
    end else begin
      state_q       <= state_d;
      wait_q        <= wait_d;
      timeout_err_q <= timeout_err_d;
      req_q         <= req_d;
      drained_q     <= drained_d;
      mem0_q        <= mem0_d;
      mem1_q        <= mem1_d;
      head_q        <= head_d;
      count_q       <= count_d;
    end
  end

  assign req_out_o     = req_q;
  assign pix_valid_o   = (count_q != 2'd0);
  assign pix_data_o    = head_q ? mem1_q : mem0_q;
  assign drained_o     = drained_q;
  assign timeout_err_o = timeout_err_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_drain.sv
`default_nettype none
// ============================================================================
// Module  : tb_fifo_drain
// Purpose : Self-checking bench for fifo_drain against a queue-based model.
// Revision: 1.0
// ============================================================================
module tb_fifo_drain;

  // Narrow counter so a wrap is reachable within a short run.
  localparam int CW = 8;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [7:0]  fill;
  logic        req_out;
  logic        ack;
  logic [15:0] pix_in;
  logic        pix_valid;
  logic        ready;
  logic [15:0] pix_data;
  logic [CW-1:0] drained;
  logic        timeout_err;
  logic        clear;

  fifo_drain #(
    .MEM_LENGTH(8),
    .PIX_WIDTH (16),
    .TIMEOUT   (15),
    .CNT_WIDTH (CW)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .enable_i     (enable),
    .fill_i       (fill),
    .req_out_o    (req_out),
    .ack_in_i     (ack),
    .pix_in_i     (pix_in),
    .pix_valid_o  (pix_valid),
    .pix_ready_i  (ready),
    .pix_data_o   (pix_data),
    .drained_o    (drained),
    .timeout_err_o(timeout_err),
    .clear_err_i  (clear)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  logic [15:0] src_q[$];
  logic [15:0] exp_q[$];
  logic [CW-1:0] drained_exp;
  int          req_rises;
  logic        prev_req;
  bit          ack_mode;
  bit          spur_en;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: record the transfers the current inputs produce, advance,
  // compare against the model, then drive the fifo side for the next cycle.
  task automatic cycle();
    logic        acc;
    logic [15:0] acc_pix;
    acc     = req_out && ack;
    acc_pix = pix_in;
    if (pix_valid && ready) begin
      if (exp_q.size() == 0) begin
        chk("pop_when_empty", {31'd0, pix_valid}, 32'd0);
      end else begin
        chk("pop_data", {16'd0, pix_data}, {16'd0, exp_q[0]});
        void'(exp_q.pop_front());
      end
    end
    @(posedge clk);
    #1;
    if (acc) begin
      exp_q.push_back(acc_pix);
      if (src_q.size() != 0) void'(src_q.pop_front());
      drained_exp++;
    end
    if (!prev_req && req_out) req_rises++;
    prev_req = req_out;
    chk("drained", {24'd0, drained}, {24'd0, drained_exp});
    chk("pix_valid", {31'd0, pix_valid}, {31'd0, (exp_q.size() != 0)});
    if (exp_q.size() != 0) chk("pix_data", {16'd0, pix_data}, {16'd0, exp_q[0]});
    fill = (src_q.size() > 255) ? 8'd255 : 8'(src_q.size());
    if (req_out) ack = ack_mode && (src_q.size() != 0);
    else         ack = spur_en && ($urandom % 4 == 0);
    pix_in = (src_q.size() != 0) ? src_q[0] : 16'($urandom);
  endtask

  task automatic run_until_empty(input int budget);
    int n = 0;
    while ((src_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
      cycle();
      n++;
    end
    chk("drain_done", 32'(src_q.size() + exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [15:0] first_pix;
    logic [15:0] b1;
    int          n;
    int          hi;
    bit          found;

    clk = 1'b0; rst_n = 1'b0; enable = 1'b0; fill = 8'd0; ack = 1'b0;
    ready = 1'b0; clear = 1'b0; pix_in = 16'd0;
    ack_mode = 1'b1; spur_en = 1'b0; drained_exp = '0; req_rises = 0; prev_req = 1'b0;

    // Reset state
    #12;
    chk("rst_req", {31'd0, req_out}, 32'd0);
    chk("rst_valid", {31'd0, pix_valid}, 32'd0);
    chk("rst_data", {16'd0, pix_data}, 32'd0);
    chk("rst_drained", {24'd0, drained}, 32'd0);
    chk("rst_err", {31'd0, timeout_err}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1: three pixels streamed straight through
    enable = 1'b1; ready = 1'b1;
    src_q = '{16'hA1, 16'hA2, 16'hA3};
    fill  = 8'd3;
    run_until_empty(40);
    repeat (3) cycle();
    chk("t1_req_pulses", 32'(req_rises), 32'd3);
    chk("t1_drained", {24'd0, drained}, 32'd3);

    // 2: downstream stalled, buffer fills at two and requests stop
    ready = 1'b0;
    for (int i = 0; i < 5; i++) src_q.push_back(16'($urandom));
    first_pix = src_q[0];
    fill = 8'd5;
    repeat (30) cycle();
    chk("t2_two_taken", {24'd0, drained}, 32'd5);
    chk("t2_req_low", {31'd0, req_out}, 32'd0);
    chk("t2_valid", {31'd0, pix_valid}, 32'd1);
    chk("t2_head", {16'd0, pix_data}, {16'd0, first_pix});
    ready = 1'b1;
    run_until_empty(60);

    // 3: ack never arrives
    ack_mode = 1'b0;
    src_q.push_back(16'h5A5A);
    fill = 8'd1;
    n = 0;
    while (!req_out && n < 20) begin cycle(); n++; end
    hi = 0;
    while (req_out && hi < 40) begin cycle(); hi++; end
    chk("t3_req_cycles", 32'(hi), 32'd15);
    chk("t3_err_set", {31'd0, timeout_err}, 32'd1);
    repeat (5) cycle();
    chk("t3_err_req_low", {31'd0, req_out}, 32'd0);
    chk("t3_err_sticky", {31'd0, timeout_err}, 32'd1);
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    chk("t3_err_clear", {31'd0, timeout_err}, 32'd0);
    ack_mode = 1'b1;
    run_until_empty(30);

    // 4: push and pop in the same cycle with one entry held
    ready = 1'b0;
    src_q.push_back(16'hB0B0);
    src_q.push_back(16'hB1B1);
    b1 = 16'hB1B1;
    fill = 8'd2;
    found = 1'b0;
    n = 0;
    while (!found && n < 30) begin
      cycle();
      n++;
      if (pix_valid && req_out && ack) found = 1'b1;
    end
    chk("t4_setup", {31'd0, found}, 32'd1);
    ready = 1'b1;
    cycle();
    chk("t4_valid", {31'd0, pix_valid}, 32'd1);
    chk("t4_data", {16'd0, pix_data}, {16'd0, b1});
    run_until_empty(30);

    // Randomised traffic with stalls, enable gaps and stray acks
    spur_en = 1'b1;
    for (int i = 0; i < 40; i++) src_q.push_back(16'($urandom));
    for (int i = 0; i < 200; i++) begin
      ready  = ($urandom % 4) != 0;
      enable = ($urandom % 8) != 0;
      cycle();
    end
    enable = 1'b1; ready = 1'b1;
    run_until_empty(200);
    spur_en = 1'b0;

    // 5: asynchronous reset during a request with one pixel buffered
    ready = 1'b0;
    src_q.push_back(16'hC0C0);
    src_q.push_back(16'hC1C1);
    found = 1'b0;
    n = 0;
    while (!found && n < 30) begin
      cycle();
      n++;
      if (pix_valid && req_out) found = 1'b1;
    end
    chk("t5_setup", {31'd0, found}, 32'd1);
    ack = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_req", {31'd0, req_out}, 32'd0);
    chk("t5_valid", {31'd0, pix_valid}, 32'd0);
    chk("t5_data", {16'd0, pix_data}, 32'd0);
    chk("t5_drained", {24'd0, drained}, 32'd0);
    src_q.delete(); exp_q.delete(); drained_exp = '0; prev_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; fill = 8'd0; ack = 1'b1; pix_in = 16'hDEAD;
    @(posedge clk); #1;
    ack = 1'b0;
    chk("t5_late_ack_drained", {24'd0, drained}, 32'd0);
    chk("t5_late_ack_valid", {31'd0, pix_valid}, 32'd0);

    // 6: enable low blocks requests; then the counter wraps
    enable = 1'b0; ready = 1'b1;
    for (int i = 0; i < 8; i++) src_q.push_back(16'($urandom));
    fill = 8'd8;
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (req_out) hi++;
    end
    chk("t6_no_req", 32'(hi), 32'd0);
    enable = 1'b1;
    for (int i = 0; i < 249; i++) src_q.push_back(16'($urandom));
    run_until_empty(1500);
    chk("t6_wrap", {24'd0, drained}, 32'(257 % (1 << CW)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
